// File: rtl/axisv_frame_arb.sv
// Frame-granular round-robin arbiter sharing one AXI4-Stream video sink between N_SRC sources.
// Define AXISV_FRAME_ARB_LEN_CHECK_EN to build the per-line length checker driving err_len_o.
module axisv_frame_arb #(
  parameter int unsigned N_SRC         = 2,
  parameter int unsigned DATA_WIDTH    = 18,
  parameter int unsigned H_PIXEL_COUNT = 800,
  parameter int unsigned V_PIXEL_COUNT = 480,
  parameter int unsigned SOF_TIMEOUT   = 1024
) (
  input  logic                        aclk_i,
  input  logic                        rst_ni,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]            s_axis_tvalid,
  input  logic [N_SRC-1:0]            s_axis_tlast,
  input  logic [N_SRC-1:0]            s_axis_tuser,
  output logic [N_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  input  logic [N_SRC-1:0]            req_i,
  output logic [N_SRC-1:0]            trigger_o,
  output logic [N_SRC-1:0]            grant_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        err_timeout_o,
  output logic                        err_len_o,
  input  logic                        err_clr_i
);

  localparam int unsigned IdxW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned LineW = $clog2(V_PIXEL_COUNT) + 1;
  localparam int unsigned TmoW  = $clog2(SOF_TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StTrig, StWaitSof, StStream} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tvalid, sel_tlast, sel_tuser;
  logic [N_SRC-1:0]      gnt_oh;
  logic [IdxW-1:0]       pick;
  logic [IdxW-1:0]       cand;
  logic                  req_found;
  logic                  hs, sof_seen, tmo_hit, last_line;

  // Mux of the granted source and its one-hot form
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = 1'b0;
    gnt_oh     = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gnt_q == IdxW'(i)) begin
        sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tuser  = s_axis_tuser[i];
        gnt_oh[i]  = 1'b1;
      end
    end
  end

  // Round-robin: first requester searching upward from last_q+1
  always_comb begin
    pick      = last_q;
    cand      = '0;
    req_found = 1'b0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IdxW'((32'(last_q) + k) % N_SRC);
      if (!req_found && req_i[cand]) begin
        pick      = cand;
        req_found = 1'b1;
      end
    end
  end

  assign hs        = (state_q == StStream) && sel_tvalid && m_axis_tready;
  assign sof_seen  = (state_q == StWaitSof) && sel_tvalid && sel_tuser;
  assign tmo_hit   = (tmo_q == TmoW'(SOF_TIMEOUT - 1));
  assign last_line = (line_q == LineW'(V_PIXEL_COUNT - 1));

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_SRC - 1);
      line_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      line_q  <= line_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    line_d  = line_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          gnt_d   = pick;
          last_d  = pick;
          state_d = StTrig;
        end
      end
      StTrig: begin
        tmo_d   = '0;
        state_d = StWaitSof;
      end
      StWaitSof: begin
        // SOF beat is held (not consumed) so STREAM forwards it next cycle
        if (sof_seen) begin
          tmo_d   = '0;
          state_d = StStream;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StStream: begin
        if (hs && sel_tlast) begin
          if (last_line) begin
            line_d  = '0;
            state_d = StIdle;
          end else begin
            line_d = line_q + LineW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    trigger_o     = '0;
    grant_o       = '0;
    busy_o        = 1'b0;
    frame_done_o  = 1'b0;
    err_timeout_o = 1'b0;
    unique case (state_q)
      StIdle: ;
      StTrig: begin
        busy_o    = 1'b1;
        grant_o   = gnt_oh;
        trigger_o = gnt_oh;
      end
      StWaitSof: begin
        busy_o        = 1'b1;
        grant_o       = gnt_oh;
        s_axis_tready = (sel_tvalid && sel_tuser) ? '0 : gnt_oh;
        err_timeout_o = !sof_seen && tmo_hit;
      end
      StStream: begin
        busy_o        = 1'b1;
        grant_o       = gnt_oh;
        m_axis_tdata  = sel_tdata;
        m_axis_tvalid = sel_tvalid;
        m_axis_tlast  = sel_tlast;
        m_axis_tuser  = sel_tuser;
        s_axis_tready = m_axis_tready ? gnt_oh : '0;
        frame_done_o  = hs && sel_tlast && last_line;
      end
      default: ;
    endcase
  end

`ifdef AXISV_FRAME_ARB_LEN_CHECK_EN
  localparam int unsigned ColW = $clog2(H_PIXEL_COUNT) + 1;

  logic [ColW-1:0] col_q, col_d;
  logic            err_len_q, err_len_d;
  logic            col_end, len_bad;

  assign col_end = (col_q == ColW'(H_PIXEL_COUNT - 1));
  assign len_bad = hs && (sel_tlast ? !col_end : col_end);

  always_ff @(posedge aclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      err_len_q <= err_len_d;
    end
  end

  always_comb begin
    col_d = col_q;
    if (state_q != StStream) begin
      col_d = '0;
    end else if (hs) begin
      col_d = sel_tlast ? '0 : col_q + ColW'(1);
    end
    // A new error in the same cycle as a clear keeps the flag set
    err_len_d = err_len_q;
    if (err_clr_i) err_len_d = 1'b0;
    if (len_bad)   err_len_d = 1'b1;
  end

  assign err_len_o = err_len_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_len_o      = 1'b0;
`endif

endmodule

// File: tb/tb_axisv_frame_arb.sv
// Scoreboard bench for axisv_frame_arb: two modelled pattern sources, directed frame scenarios.
module tb_axisv_frame_arb;

  localparam int unsigned NS = 2;
  localparam int unsigned DW = 18;
  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned TO = 16;
`ifdef AXISV_FRAME_ARB_LEN_CHECK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    logic          done;
    logic [NS-1:0] gnt;
  } beat_t;

  logic              aclk = 1'b0;
  logic              rst_n;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [NS-1:0]     req, trigger, grant;
  logic              busy, frame_done, err_timeout, err_len, err_clr;

  always #5 aclk = ~aclk;

  axisv_frame_arb #(
    .N_SRC(NS), .DATA_WIDTH(DW), .H_PIXEL_COUNT(H), .V_PIXEL_COUNT(V), .SOF_TIMEOUT(TO)
  ) dut (
    .aclk_i(aclk), .rst_ni(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .req_i(req), .trigger_o(trigger), .grant_o(grant), .busy_o(busy),
    .frame_done_o(frame_done), .err_timeout_o(err_timeout), .err_len_o(err_len),
    .err_clr_i(err_clr)
  );

  int    n_chk = 0;
  int    n_pass = 0;
  beat_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] enc(input int s, input int l, input int c);
    return DW'((s << 10) | (l << 5) | c);
  endfunction

  task automatic push_frame(input int s, input bit short_first);
    beat_t e;
    int    lc;
    for (int l = 0; l < int'(V); l++) begin
      lc = (short_first && l == 0) ? 6 : int'(H) - 1;
      for (int c = 0; c <= lc; c++) begin
        e.data = enc(s, l, c);
        e.last = (c == lc);
        e.user = (l == 0 && c == 0);
        e.done = (l == int'(V) - 1 && c == lc);
        e.gnt  = NS'(1 << s);
        sb.push_back(e);
      end
    end
  endtask

  // Source model configuration (stimulus writes) and state (model writes)
  bit   mute[NS], short_l[NS], stall_en;
  int   junk_n[NS];
  bit   act[NS];
  int   junk_left[NS], ln[NS], cl[NS], junk_hs[NS], trig_cnt[NS];
  int   cyc, t_trig1, t_tmo;
  logic [NS-1:0] hs_s, trg;

  function automatic bit beat_last(input int i);
    return cl[i] == ((short_l[i] && ln[i] == 0) ? 6 : int'(H) - 1);
  endfunction

  initial begin
    logic [NS-1:0]    v, l, u;
    logic [NS*DW-1:0] td;
    cyc = 0; t_trig1 = 0; t_tmo = 0;
    for (int i = 0; i < int'(NS); i++) begin
      act[i] = 0; junk_left[i] = 0; ln[i] = 0; cl[i] = 0; junk_hs[i] = 0; trig_cnt[i] = 0;
    end
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      hs_s = s_axis_tvalid & s_axis_tready;
      trg  = trigger;
      if (err_timeout) t_tmo = cyc;
      if (trigger[1])  t_trig1 = cyc;
      @(posedge aclk);
      #1;
      cyc++;
      for (int i = 0; i < int'(NS); i++) begin
        if (!rst_n) act[i] = 0;
        if (hs_s[i]) begin
          if (junk_left[i] > 0) begin
            junk_left[i]--;
            junk_hs[i]++;
          end else if (beat_last(i)) begin
            cl[i] = 0;
            if (ln[i] == int'(V) - 1) act[i] = 0;
            else ln[i]++;
          end else begin
            cl[i]++;
          end
        end
        if (trg[i]) begin
          act[i] = 1; ln[i] = 0; cl[i] = 0; junk_left[i] = junk_n[i]; trig_cnt[i]++;
        end
        v[i] = act[i] && !mute[i];
        u[i] = 1'b0;
        l[i] = 1'b0;
        td[i*DW +: DW] = '0;
        if (v[i]) begin
          if (junk_left[i] > 0) begin
            td[i*DW +: DW] = '1;
          end else begin
            u[i] = (ln[i] == 0 && cl[i] == 0);
            l[i] = beat_last(i);
            td[i*DW +: DW] = enc(i, ln[i], cl[i]);
          end
        end
      end
      s_axis_tvalid = v; s_axis_tlast = l; s_axis_tuser = u; s_axis_tdata = td;
      m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every output handshake pops one expected beat
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis_tdata), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk("beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
              32'({e.data, e.last, e.user}));
          chk("frame_done", 32'(frame_done), 32'(e.done));
          chk("grant", 32'(grant), 32'(e.gnt));
        end
      end else if (frame_done) begin
        chk("frame_done_no_beat", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge aclk);
      if (frame_done) break;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_busy(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge aclk);
      if (busy) break;
    end
    chk("busy_seen", 32'(busy), 32'd1);
  endtask

  task automatic wait_tmo(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge aclk);
      if (err_timeout) break;
    end
    chk("timeout_seen", 32'(err_timeout), 32'd1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; req = '0; err_clr = 1'b0; stall_en = 0;
    for (int i = 0; i < int'(NS); i++) begin
      mute[i] = 0; short_l[i] = 0; junk_n[i] = 0;
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_m_tvalid", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_err", 32'({err_len, err_timeout, frame_done}), 32'd0);
    step();
    rst_n = 1'b1;

    // Single frame from source 0
    base = trig_cnt[0];
    push_frame(0, 0);
    step(); req = 2'b01;
    wait_busy(10);
    step(); req = 2'b00;
    wait_done(200);
    @(negedge aclk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("trigger_count", 32'(trig_cnt[0] - base), 32'd1);
    chk("err_len_clean", 32'(err_len), 32'd0);

    // Round-robin over three frames from reset: 0, 1, 0
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    push_frame(0, 0); push_frame(1, 0); push_frame(0, 0);
    req = 2'b11;
    wait_done(200);
    wait_done(200);
    wait_busy(10);
    step(); req = 2'b00;
    wait_done(200);

    // Five non-SOF beats are dropped before the frame
    junk_n[0] = 5;
    base = junk_hs[0];
    push_frame(0, 0);
    step(); req = 2'b01;
    wait_busy(10);
    step(); req = 2'b00;
    wait_done(200);
    chk("junk_dropped", 32'(junk_hs[0] - base), 32'd5);
    junk_n[0] = 0;

    // Source 1 silent: timeout, then source 0 granted
    mute[1] = 1;
    push_frame(0, 0);
    step(); req = 2'b11;
    wait_tmo(40);
    wait_busy(10);
    chk("grant_after_tmo", 32'(grant), 32'd1);
    step(); req = 2'b00;
    wait_done(200);
    chk("tmo_latency", 32'(t_tmo - t_trig1), 32'(TO));
    mute[1] = 0;

    // Random output stalls
    stall_en = 1;
    push_frame(0, 0);
    step(); req = 2'b01;
    wait_busy(10);
    step(); req = 2'b00;
    wait_done(500);
    stall_en = 0;

    // Short first line
    short_l[0] = 1;
    push_frame(0, 1);
    step(); req = 2'b01;
    wait_busy(10);
    step(); req = 2'b00;
    wait_done(200);
    short_l[0] = 0;
    repeat (3) @(negedge aclk);
    chk("err_len_set", 32'(err_len), 32'(EXP_LEN_ERR));
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    @(negedge aclk);
    chk("err_len_cleared", 32'(err_len), 32'd0);

    repeat (5) @(negedge aclk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
